// File: rtl/ui_pkg.sv
// rtl/ui_pkg.sv - shared constants and event type for the input event scheduler
package ui_pkg;

  localparam int NUM_BTN         = 4;
  localparam int DEBOUNCE_CYCLES = 16;
  localparam int REPEAT_DELAY    = 64;
  localparam int REPEAT_PERIOD   = 16;

  // Wide enough for the largest legal button count (8).
  localparam int EVT_ID_W = 3;

  // Event ids consumed by the display glue.
  localparam int EVT_COLOR  = 0;
  localparam int EVT_BRIGHT = 1;

  typedef struct packed {
    logic                valid;
    logic                is_repeat;
    logic [EVT_ID_W-1:0] id;
  } evt_t;

endpackage

// File: rtl/input_event_scheduler_if.sv
// rtl/input_event_scheduler_if.sv - valid/ready event channel between scheduler and consumer
interface input_event_scheduler_if #(
  parameter int ID_W = $clog2(ui_pkg::NUM_BTN)
) ();

  logic            evt_valid;
  logic [ID_W-1:0] evt_id;
  logic            evt_repeat;
  logic            evt_ready;

  modport master (output evt_valid, output evt_id, output evt_repeat, input  evt_ready);
  modport slave  (input  evt_valid, input  evt_id, input  evt_repeat, output evt_ready);

endinterface

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - per-button synchronizer, debouncer, edge detector and repeat timer
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = ui_pkg::DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = ui_pkg::REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = ui_pkg::REPEAT_PERIOD
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic evt_fire,
  output logic evt_kind
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(REPEAT_DELAY);

  logic [1:0]        sync_q;
  logic              sync;
  logic [CNT_W-1:0]  cnt;
  logic              stable_d;
  logic [HOLD_W-1:0] hold;
  logic              press;
  logic              rep_hit;

  assign sync = sync_q[1];

  assign press   = stable & ~stable_d;
  // Reaching REPEAT_DELAY-1 means this edge is the REPEAT_DELAY-th cycle after the press event.
  assign rep_hit = stable & stable_d & (hold == HOLD_W'(REPEAT_DELAY - 1));

  assign evt_fire = press | rep_hit;
  assign evt_kind = rep_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= '0;
      cnt      <= '0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      hold     <= '0;
    end else begin
      sync_q   <= {sync_q[0], raw};
      stable_d <= stable;

      if (sync == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable <= sync;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end

      // Wrapping back by REPEAT_PERIOD keeps the timer bounded while the button stays held.
      if (!stable || press) begin
        hold <= '0;
      end else if (rep_hit) begin
        hold <= HOLD_W'(REPEAT_DELAY - REPEAT_PERIOD);
      end else begin
        hold <= hold + HOLD_W'(1);
      end
    end
  end

endmodule

// File: rtl/input_event_scheduler.sv
// rtl/input_event_scheduler.sv - debounced button events merged and round-robin arbitrated onto one channel
module input_event_scheduler #(
  parameter int NUM_BTN         = ui_pkg::NUM_BTN,
  parameter int DEBOUNCE_CYCLES = ui_pkg::DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = ui_pkg::REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = ui_pkg::REPEAT_PERIOD
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_BTN-1:0]       btn_raw,
  output logic [NUM_BTN-1:0]       btn_stable,
  input_event_scheduler_if.master  evt,
  output logic [NUM_BTN-1:0]       pending,
  output logic                     overrun,
  input  logic                     overrun_clr
);

  localparam int ID_W = $clog2(NUM_BTN);

  logic [NUM_BTN-1:0] fire;
  logic [NUM_BTN-1:0] fire_kind;
  logic [NUM_BTN-1:0] kind;
  logic [NUM_BTN-1:0] clr;
  logic [ID_W-1:0]    last_grant;
  logic [ID_W-1:0]    grant_idx;
  logic [ID_W:0]      cand;
  logic               grant_found;
  logic               load;

  logic               evt_valid_q;
  logic [ID_W-1:0]    evt_id_q;
  logic               evt_repeat_q;

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    btn_conditioner #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_cond (
      .clk      (clk),
      .reset    (reset),
      .raw      (btn_raw[gi]),
      .stable   (btn_stable[gi]),
      .evt_fire (fire[gi]),
      .evt_kind (fire_kind[gi])
    );
  end

  // Search starts just after the last grant; the extra bit lets the sum wrap for non-power-of-two counts.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_BTN; k++) begin
      cand = {1'b0, last_grant} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_BTN)) begin
        cand = cand - (ID_W+1)'(NUM_BTN);
      end
      if (!grant_found && pending[cand[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[ID_W-1:0];
      end
    end
  end

  assign load = (!evt_valid_q || evt.evt_ready) && grant_found;
  assign clr  = load ? (NUM_BTN'(1) << grant_idx) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      pending      <= '0;
      kind         <= '0;
      overrun      <= 1'b0;
      last_grant   <= ID_W'(NUM_BTN - 1);
      evt_valid_q  <= 1'b0;
      evt_id_q     <= '0;
      evt_repeat_q <= 1'b0;
    end else begin
      // A fresh event on a bit being granted this cycle survives as a new pending entry.
      pending <= (pending & ~clr) | fire;
      kind    <= (kind & ~fire) | (fire_kind & fire);

      if (|(fire & pending)) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end

      if (load) begin
        evt_valid_q  <= 1'b1;
        evt_id_q     <= grant_idx;
        evt_repeat_q <= kind[grant_idx];
        last_grant   <= grant_idx;
      end else if (evt.evt_ready) begin
        evt_valid_q  <= 1'b0;
      end
    end
  end

  assign evt.evt_valid  = evt_valid_q;
  assign evt.evt_id     = evt_id_q;
  assign evt.evt_repeat = evt_repeat_q;

endmodule

// File: tb/tb_input_event_scheduler.sv
// tb/tb_input_event_scheduler.sv - scoreboard bench with a cycle-level reference model of the scheduler
module tb_input_event_scheduler;

  localparam int NB  = 4;
  localparam int DC  = 4;
  localparam int RD  = 8;
  localparam int RP  = 4;
  localparam int IDW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NB-1:0] btn_raw = '0;
  logic [NB-1:0] btn_stable;
  logic [NB-1:0] pending;
  logic          overrun;
  logic          clr = 1'b0;
  logic          ready_drv = 1'b1;

  input_event_scheduler_if #(.ID_W(IDW)) evt ();
  assign evt.evt_ready = ready_drv;

  input_event_scheduler #(
    .NUM_BTN(NB), .DEBOUNCE_CYCLES(DC), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .btn_stable(btn_stable), .evt(evt),
    .pending(pending), .overrun(overrun), .overrun_clr(clr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int edge_n = 0;
  bit mon_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Reference model: events derived from press time and hold age, plus a pending set and round-robin pick.
  logic [NB-1:0] m_stable = '0, m_pend = '0, m_kind = '0, m_fire, m_fkind, pend_pre;
  logic [NB-1:0] samp_prev = '0, samp_old = '0;
  logic          m_ovr = 1'b0, m_valid = 1'b0;
  int            m_last = NB - 1;
  int            m_run[NB];
  int            m_rise[NB];
  int            age, g, c;
  bit            found;
  ui_pkg::evt_t  ev;
  ui_pkg::evt_t  sbq[$];

  int   xfer_id[$];
  logic xfer_rep[$];
  int   xfer_t[$];

  always @(posedge clk) begin
    edge_n++;
    if (reset) begin
      m_stable = '0; m_pend = '0; m_kind = '0; m_ovr = 1'b0; m_valid = 1'b0; m_last = NB - 1;
      for (int i = 0; i < NB; i++) begin m_run[i] = 0; m_rise[i] = -1000; end
      samp_prev = '0; samp_old = '0;
      sbq.delete();
    end else begin
      m_fire = '0; m_fkind = '0;
      for (int i = 0; i < NB; i++) begin
        if (m_stable[i]) begin
          age = edge_n - m_rise[i] - 1;
          if (age == 0) m_fire[i] = 1'b1;
          else if (age >= RD && ((age - RD) % RP) == 0) begin m_fire[i] = 1'b1; m_fkind[i] = 1'b1; end
        end
      end
      pend_pre = m_pend;
      if ((!m_valid || ready_drv) && m_pend != '0) begin
        found = 1'b0; g = 0;
        for (int k = 1; k <= NB; k++) begin
          c = (m_last + k) % NB;
          if (!found && m_pend[c]) begin found = 1'b1; g = c; end
        end
        ev.valid = 1'b1; ev.is_repeat = m_kind[g]; ev.id = 3'(g);
        sbq.push_back(ev);
        m_pend[g] = 1'b0; m_last = g; m_valid = 1'b1;
      end else if (ready_drv) begin
        m_valid = 1'b0;
      end
      if ((m_fire & pend_pre) != '0) m_ovr = 1'b1;
      else if (clr) m_ovr = 1'b0;
      m_pend = m_pend | m_fire;
      m_kind = (m_kind & ~m_fire) | (m_fkind & m_fire);
      for (int i = 0; i < NB; i++) begin
        if (samp_old[i] != m_stable[i]) begin
          m_run[i]++;
          if (m_run[i] == DC) begin
            m_stable[i] = samp_old[i]; m_run[i] = 0;
            if (samp_old[i]) m_rise[i] = edge_n;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      samp_old = samp_prev; samp_prev = btn_raw;
    end
  end

  // Monitor: per-cycle state compare plus scoreboard pop on every DUT transfer.
  ui_pkg::evt_t got;
  always @(negedge clk) begin
    if (mon_on) begin
      check("btn_stable", btn_stable, m_stable);
      check("pending", pending, m_pend);
      check("overrun", overrun, m_ovr);
      check("evt_valid", evt.evt_valid, m_valid);
      if (evt.evt_valid && ready_drv && !reset) begin
        xfer_id.push_back(int'(evt.evt_id)); xfer_rep.push_back(evt.evt_repeat); xfer_t.push_back(edge_n);
        check("sb_has_entry", sbq.size() != 0, 1);
        if (sbq.size() != 0) begin
          got = sbq.pop_front();
          check("evt_id", evt.evt_id, got.id);
          check("evt_repeat", evt.evt_repeat, got.is_repeat);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_log();
    xfer_id.delete(); xfer_rep.delete(); xfer_t.delete();
  endtask

  int stable_at, valid_at, width, seen;

  initial begin
    cyc(1);
    mon_on = 1'b1;
    cyc(2);
    check("rst_valid", evt.evt_valid, 0);
    check("rst_id", evt.evt_id, 0);
    check("rst_repeat", evt.evt_repeat, 0);
    check("rst_pending", pending, 0);
    check("rst_stable", btn_stable, 0);
    check("rst_overrun", overrun, 0);
    reset = 1'b0;

    // Fairness: simultaneous press, then the first repeat burst restarts at 0.
    clear_log();
    btn_raw = 4'hF; cyc(12); btn_raw = '0; cyc(30);
    check("fair_count", xfer_id.size(), 8);
    for (int k = 0; k < 8; k++) check("fair_id", (k < xfer_id.size()) ? xfer_id[k] : 99, k % 4);

    // Clean press timing.
    clear_log();
    btn_raw[0] = 1'b1; stable_at = -1; valid_at = -1; width = 0;
    for (int k = 1; k <= 12; k++) begin
      cyc(1);
      if (btn_stable[0] && stable_at < 0) stable_at = k;
      if (evt.evt_valid) begin if (valid_at < 0) valid_at = k; width++; end
    end
    check("press_stable_edge", stable_at, 6);
    check("press_valid_edge", valid_at, 8);
    check("press_valid_width", width, 1);
    btn_raw[0] = 1'b0; cyc(20);

    // Bounce shorter than the debounce window.
    clear_log(); seen = 0;
    for (int k = 0; k < 10; k++) begin
      btn_raw[1] = ~btn_raw[1];
      cyc(1); if (btn_stable[1]) seen = 1;
      cyc(1); if (btn_stable[1]) seen = 1;
    end
    btn_raw[1] = 1'b0; cyc(20);
    check("bounce_stable", seen, 0);
    check("bounce_events", xfer_id.size(), 0);

    // Hold-to-repeat spacing.
    clear_log();
    btn_raw[2] = 1'b1; cyc(30); btn_raw[2] = 1'b0; cyc(30);
    check("hold_enough", xfer_id.size() >= 3, 1);
    if (xfer_id.size() >= 3) begin
      check("hold_press_kind", xfer_rep[0], 0);
      check("hold_rep1_kind", xfer_rep[1], 1);
      check("hold_rep1_gap", xfer_t[1] - xfer_t[0], RD);
      check("hold_rep2_gap", xfer_t[2] - xfer_t[0], RD + RP);
    end

    // Backpressure with merged repeats.
    ready_drv = 1'b0; btn_raw[3] = 1'b1; cyc(30);
    check("bp_valid", evt.evt_valid, 1);
    check("bp_id", evt.evt_id, 3);
    check("bp_repeat", evt.evt_repeat, 0);
    check("bp_overrun", overrun, 1);
    btn_raw[3] = 1'b0; cyc(10);
    clear_log(); ready_drv = 1'b1; cyc(4);
    check("bp_drain_count", xfer_id.size(), 2);
    if (xfer_id.size() >= 2) begin
      check("bp_next_id", xfer_id[1], 3);
      check("bp_next_repeat", xfer_rep[1], 1);
    end
    clr = 1'b1; cyc(1); clr = 1'b0; cyc(1);
    check("bp_overrun_cleared", overrun, 0);

    // Reset while an event is stalled on the channel.
    ready_drv = 1'b0; btn_raw = 4'hF; cyc(20);
    check("mid_valid_before", evt.evt_valid, 1);
    reset = 1'b1; cyc(1);
    check("mid_valid", evt.evt_valid, 0);
    check("mid_pending", pending, 0);
    check("mid_stable", btn_stable, 0);
    check("mid_overrun", overrun, 0);
    reset = 1'b0; ready_drv = 1'b1; valid_at = -1;
    for (int k = 1; k <= 15; k++) begin
      cyc(1);
      if (evt.evt_valid && valid_at < 0) valid_at = k;
    end
    check("mid_first_event_edge", valid_at, 8);
    btn_raw = '0; cyc(30);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NB; i++) if ($urandom_range(0, 99) < 8) btn_raw[i] = ~btn_raw[i];
      ready_drv = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 19) == 0);
      reset = ($urandom_range(0, 499) == 0);
      cyc(1);
    end
    reset = 1'b0; btn_raw = '0; ready_drv = 1'b1; clr = 1'b0;
    cyc(50);
    check("drain_empty", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
